// File: rtl/llc_arb_pkg.sv
// ---------------------------------------------------------------------------
// llc_arb_pkg
// Shared types and constants for the LLC request arbiter.
//   - Field typedefs for the coherence and DMA request channels.
//   - Message encodings used by the arbiter (REQ_GETS, REQ_DMA_READ, ...).
//   - llc_arb_state_t: arbiter FSM states.
//   - llc_arb_req_t: merged request format (DMA field widths plus is_dma).
//   - widen_coh_req(): converts coherence fields to the merged format.
// ---------------------------------------------------------------------------
package llc_arb_pkg;

    localparam int LLC_ARB_RUN_BITS = 4;

    localparam int MIX_MSG_TYPE_WIDTH    = 3;
    localparam int HPROT_WIDTH           = 1;
    localparam int LINE_ADDR_WIDTH       = 26;
    localparam int LINE_WIDTH            = 64;
    localparam int CACHE_ID_WIDTH        = 4;
    localparam int LLC_COH_DEV_ID_WIDTH  = 6;
    localparam int WORD_OFFSET_WIDTH     = 2;
    localparam int DMA_WORD_OFFSET_WIDTH = 4;

    typedef logic [MIX_MSG_TYPE_WIDTH-1:0]    mix_msg_t;
    typedef logic [HPROT_WIDTH-1:0]           hprot_t;
    typedef logic [LINE_ADDR_WIDTH-1:0]       line_addr_t;
    typedef logic [LINE_WIDTH-1:0]            line_t;
    typedef logic [CACHE_ID_WIDTH-1:0]        cache_id_t;
    typedef logic [LLC_COH_DEV_ID_WIDTH-1:0]  llc_coh_dev_id_t;
    typedef logic [WORD_OFFSET_WIDTH-1:0]     word_offset_t;
    typedef logic [DMA_WORD_OFFSET_WIDTH-1:0] dma_word_offset_t;
    typedef logic [LLC_ARB_RUN_BITS-1:0]      run_cnt_t;

    localparam mix_msg_t REQ_GETS      = 3'b000;
    localparam mix_msg_t REQ_GETM      = 3'b001;
    localparam mix_msg_t REQ_DMA_READ  = 3'b110;
    localparam mix_msg_t REQ_DMA_WRITE = 3'b111;

    typedef enum logic {
        RR       = 1'b0,
        DMA_LOCK = 1'b1
    } llc_arb_state_t;

    typedef struct packed {
        mix_msg_t         coh_msg;
        hprot_t           hprot;
        line_addr_t       addr;
        line_t            line;
        llc_coh_dev_id_t  req_id;
        dma_word_offset_t word_offset;
        dma_word_offset_t valid_words;
        logic             is_dma;
    } llc_arb_req_t;

    // Coherence ids and offsets are narrower than their DMA counterparts;
    // zero-extension keeps their numeric value unchanged for the LLC core.
    function automatic llc_arb_req_t widen_coh_req(
        input mix_msg_t     coh_msg,
        input hprot_t       hprot,
        input line_addr_t   addr,
        input line_t        line,
        input cache_id_t    req_id,
        input word_offset_t word_offset,
        input word_offset_t valid_words
    );
        llc_arb_req_t r;
        r.coh_msg     = coh_msg;
        r.hprot       = hprot;
        r.addr        = addr;
        r.line        = line;
        r.req_id      = llc_coh_dev_id_t'(req_id);
        r.word_offset = dma_word_offset_t'(word_offset);
        r.valid_words = dma_word_offset_t'(valid_words);
        r.is_dma      = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/llc_arb_out_reg.sv
// ---------------------------------------------------------------------------
// llc_arb_out_reg
// One-entry valid/ready register holding the merged request.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   load_i          a new request is granted this cycle (captures data_i)
//   data_i          merged request to capture
//   ready_i         downstream accepts the held request this cycle
//   valid_o         slot holds a request
//   data_o          held request (stable while valid_o && !ready_i)
// ---------------------------------------------------------------------------
module llc_arb_out_reg
    import llc_arb_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  llc_arb_req_t data_i,
    input  logic         ready_i,
    output logic         valid_o,
    output llc_arb_req_t data_o
);

    logic         valid_q;
    llc_arb_req_t data_q;

    // A load wins over a drain so that draining and refilling in the same
    // cycle leaves the slot full with the new request and no bubble.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
        end else if (ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/llc_req_arbiter.sv
// ---------------------------------------------------------------------------
// llc_req_arbiter
// Merges the coherence request channel and the DMA request channel into one
// registered request stream for the LLC core. Weighted round-robin between
// the channels (DMA_WEIGHT consecutive DMA grants before the coherence
// channel regains priority) and a lock onto the DMA channel for the whole of
// a multi-line DMA write burst.
// Ports:
//   clk, rst                          clock, asynchronous active-low reset
//   llc_req_in_*                      coherence request channel (valid/ready)
//   llc_dma_req_in_*                  DMA request channel (valid/ready)
//   req_out_*                         merged request, DMA field widths
//   req_out_is_dma                    request came from the DMA channel
//   grant_cnt_req, grant_cnt_dma      saturating grant counters, only when
//                                     LLC_REQ_ARB_STATS_EN is defined
// ---------------------------------------------------------------------------
module llc_req_arbiter
    import llc_arb_pkg::*;
#(
    parameter int DMA_WEIGHT = 1
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             llc_req_in_valid,
    output logic             llc_req_in_ready,
    input  mix_msg_t         llc_req_in_coh_msg,
    input  hprot_t           llc_req_in_hprot,
    input  line_addr_t       llc_req_in_addr,
    input  line_t            llc_req_in_line,
    input  cache_id_t        llc_req_in_req_id,
    input  word_offset_t     llc_req_in_word_offset,
    input  word_offset_t     llc_req_in_valid_words,

    input  logic             llc_dma_req_in_valid,
    output logic             llc_dma_req_in_ready,
    input  mix_msg_t         llc_dma_req_in_coh_msg,
    input  hprot_t           llc_dma_req_in_hprot,
    input  line_addr_t       llc_dma_req_in_addr,
    input  line_t            llc_dma_req_in_line,
    input  llc_coh_dev_id_t  llc_dma_req_in_req_id,
    input  dma_word_offset_t llc_dma_req_in_word_offset,
    input  dma_word_offset_t llc_dma_req_in_valid_words,

    output logic             req_out_valid,
    input  logic             req_out_ready,
    output mix_msg_t         req_out_coh_msg,
    output hprot_t           req_out_hprot,
    output line_addr_t       req_out_addr,
    output line_t            req_out_line,
    output llc_coh_dev_id_t  req_out_req_id,
    output dma_word_offset_t req_out_word_offset,
    output dma_word_offset_t req_out_valid_words,
    output logic             req_out_is_dma
`ifdef LLC_REQ_ARB_STATS_EN
    ,
    output logic [31:0]      grant_cnt_req,
    output logic [31:0]      grant_cnt_dma
`endif
);

    // DMA run value at which the coherence channel regains priority.
    localparam run_cnt_t WEIGHT_LAST = run_cnt_t'(DMA_WEIGHT - 1);

    llc_arb_state_t state_q, state_d;
    logic           prio_q, prio_d;
    run_cnt_t       dmaRun_q, dmaRun_d;

    logic           slotFree;
    logic           outValid;
    logic           selReqRr;
    logic           selDmaRr;
    logic           reqGrant;
    logic           dmaGrant;
    logic           dmaBurstMore;
    llc_arb_req_t   grantData;
    llc_arb_req_t   outData;

    assign slotFree = !outValid || req_out_ready;

    // Round-robin choice when both channels are valid; a lone valid channel
    // always wins regardless of prio.
    assign selReqRr = llc_req_in_valid     && (!llc_dma_req_in_valid || !prio_q);
    assign selDmaRr = llc_dma_req_in_valid && (!llc_req_in_valid     ||  prio_q);

    // Readies are gated by rst so both read 0 while reset is asserted.
    assign llc_req_in_ready     = rst && slotFree && (state_q == RR) && selReqRr;
    assign llc_dma_req_in_ready = rst && slotFree &&
                                  ((state_q == DMA_LOCK) ? llc_dma_req_in_valid : selDmaRr);

    assign reqGrant = llc_req_in_valid     && llc_req_in_ready;
    assign dmaGrant = llc_dma_req_in_valid && llc_dma_req_in_ready;

    assign dmaBurstMore = (llc_dma_req_in_coh_msg == REQ_DMA_WRITE) &&
                          (llc_dma_req_in_hprot == 1'b1);

    // Select the granted channel's fields in the merged format.
    always_comb begin
        if (dmaGrant) begin
            grantData.coh_msg     = llc_dma_req_in_coh_msg;
            grantData.hprot       = llc_dma_req_in_hprot;
            grantData.addr        = llc_dma_req_in_addr;
            grantData.line        = llc_dma_req_in_line;
            grantData.req_id      = llc_dma_req_in_req_id;
            grantData.word_offset = llc_dma_req_in_word_offset;
            grantData.valid_words = llc_dma_req_in_valid_words;
            grantData.is_dma      = 1'b1;
        end else begin
            grantData = widen_coh_req(llc_req_in_coh_msg, llc_req_in_hprot,
                                      llc_req_in_addr, llc_req_in_line,
                                      llc_req_in_req_id, llc_req_in_word_offset,
                                      llc_req_in_valid_words);
        end
    end

    // Next-state for the arbitration FSM. The line that opens a burst and
    // the lines inside it leave dma_run alone; the closing line hands
    // priority straight back to the coherence channel.
    always_comb begin
        state_d  = state_q;
        prio_d   = prio_q;
        dmaRun_d = dmaRun_q;
        case (state_q)
            RR: begin
                if (reqGrant) begin
                    prio_d   = 1'b1;
                    dmaRun_d = '0;
                end else if (dmaGrant) begin
                    if (dmaBurstMore) begin
                        state_d = DMA_LOCK;
                    end else if (dmaRun_q == WEIGHT_LAST) begin
                        prio_d   = 1'b0;
                        dmaRun_d = '0;
                    end else begin
                        dmaRun_d = dmaRun_q + run_cnt_t'(1);
                    end
                end
            end
            DMA_LOCK: begin
                if (dmaGrant && (llc_dma_req_in_hprot == 1'b0)) begin
                    state_d  = RR;
                    prio_d   = 1'b0;
                    dmaRun_d = '0;
                end
            end
            default: begin
                state_d = RR;
            end
        endcase
    end

    // Arbitration state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= RR;
            prio_q   <= 1'b0;
            dmaRun_q <= '0;
        end else begin
            state_q  <= state_d;
            prio_q   <= prio_d;
            dmaRun_q <= dmaRun_d;
        end
    end

    llc_arb_out_reg u_out_reg (
        .clk_i   (clk),
        .rst_ni  (rst),
        .load_i  (reqGrant || dmaGrant),
        .data_i  (grantData),
        .ready_i (req_out_ready),
        .valid_o (outValid),
        .data_o  (outData)
    );

    assign req_out_valid       = outValid;
    assign req_out_coh_msg     = outData.coh_msg;
    assign req_out_hprot       = outData.hprot;
    assign req_out_addr        = outData.addr;
    assign req_out_line        = outData.line;
    assign req_out_req_id      = outData.req_id;
    assign req_out_word_offset = outData.word_offset;
    assign req_out_valid_words = outData.valid_words;
    assign req_out_is_dma      = outData.is_dma;

`ifdef LLC_REQ_ARB_STATS_EN
    logic [31:0] grantCntReq_q;
    logic [31:0] grantCntDma_q;

    // Per-channel grant counters that stick at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grantCntReq_q <= '0;
            grantCntDma_q <= '0;
        end else begin
            if (reqGrant && (grantCntReq_q != 32'hFFFF_FFFF)) begin
                grantCntReq_q <= grantCntReq_q + 32'd1;
            end
            if (dmaGrant && (grantCntDma_q != 32'hFFFF_FFFF)) begin
                grantCntDma_q <= grantCntDma_q + 32'd1;
            end
        end
    end

    assign grant_cnt_req = grantCntReq_q;
    assign grant_cnt_dma = grantCntDma_q;
`endif

endmodule

// File: tb/tb_llc_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_llc_req_arbiter
// Directed bench for llc_req_arbiter with DMA_WEIGHT=2. A table of
// per-cycle vectors walks through weighted round-robin, coherence-only
// traffic, a locked DMA write burst and output back-pressure; hand-written
// sequences cover reset, reset in the middle of a burst, field widening and
// (with LLC_REQ_ARB_STATS_EN) the grant counters.
// ---------------------------------------------------------------------------
module tb_llc_req_arbiter;
    import llc_arb_pkg::*;

    localparam int NUM_VEC = 23;

    logic             clk;
    logic             rst;
    logic             llc_req_in_valid;
    logic             llc_req_in_ready;
    mix_msg_t         llc_req_in_coh_msg;
    hprot_t           llc_req_in_hprot;
    line_addr_t       llc_req_in_addr;
    line_t            llc_req_in_line;
    cache_id_t        llc_req_in_req_id;
    word_offset_t     llc_req_in_word_offset;
    word_offset_t     llc_req_in_valid_words;
    logic             llc_dma_req_in_valid;
    logic             llc_dma_req_in_ready;
    mix_msg_t         llc_dma_req_in_coh_msg;
    hprot_t           llc_dma_req_in_hprot;
    line_addr_t       llc_dma_req_in_addr;
    line_t            llc_dma_req_in_line;
    llc_coh_dev_id_t  llc_dma_req_in_req_id;
    dma_word_offset_t llc_dma_req_in_word_offset;
    dma_word_offset_t llc_dma_req_in_valid_words;
    logic             req_out_valid;
    logic             req_out_ready;
    mix_msg_t         req_out_coh_msg;
    hprot_t           req_out_hprot;
    line_addr_t       req_out_addr;
    line_t            req_out_line;
    llc_coh_dev_id_t  req_out_req_id;
    dma_word_offset_t req_out_word_offset;
    dma_word_offset_t req_out_valid_words;
    logic             req_out_is_dma;
`ifdef LLC_REQ_ARB_STATS_EN
    logic [31:0]      grant_cnt_req;
    logic [31:0]      grant_cnt_dma;
`endif

    int total;
    int bad;
    int nReqGrants;
    int nDmaGrants;

    typedef struct {
        logic            reqV;
        logic [3:0]      reqId;
        logic            dmaV;
        logic            isWrite;
        logic            hp;
        logic [5:0]      dmaId;
        logic            outRdy;
        logic            eReqRdy;
        logic            eDmaRdy;
        logic            eOutV;
        logic            eIsDma;
        logic [5:0]      eId;
    } vec_t;

    vec_t vecs [NUM_VEC];

    llc_req_arbiter #(.DMA_WEIGHT(2)) dut (
        .clk                        (clk),
        .rst                        (rst),
        .llc_req_in_valid           (llc_req_in_valid),
        .llc_req_in_ready           (llc_req_in_ready),
        .llc_req_in_coh_msg         (llc_req_in_coh_msg),
        .llc_req_in_hprot           (llc_req_in_hprot),
        .llc_req_in_addr            (llc_req_in_addr),
        .llc_req_in_line            (llc_req_in_line),
        .llc_req_in_req_id          (llc_req_in_req_id),
        .llc_req_in_word_offset     (llc_req_in_word_offset),
        .llc_req_in_valid_words     (llc_req_in_valid_words),
        .llc_dma_req_in_valid       (llc_dma_req_in_valid),
        .llc_dma_req_in_ready       (llc_dma_req_in_ready),
        .llc_dma_req_in_coh_msg     (llc_dma_req_in_coh_msg),
        .llc_dma_req_in_hprot       (llc_dma_req_in_hprot),
        .llc_dma_req_in_addr        (llc_dma_req_in_addr),
        .llc_dma_req_in_line        (llc_dma_req_in_line),
        .llc_dma_req_in_req_id      (llc_dma_req_in_req_id),
        .llc_dma_req_in_word_offset (llc_dma_req_in_word_offset),
        .llc_dma_req_in_valid_words (llc_dma_req_in_valid_words),
        .req_out_valid              (req_out_valid),
        .req_out_ready              (req_out_ready),
        .req_out_coh_msg            (req_out_coh_msg),
        .req_out_hprot              (req_out_hprot),
        .req_out_addr               (req_out_addr),
        .req_out_line               (req_out_line),
        .req_out_req_id             (req_out_req_id),
        .req_out_word_offset        (req_out_word_offset),
        .req_out_valid_words        (req_out_valid_words),
        .req_out_is_dma             (req_out_is_dma)
`ifdef LLC_REQ_ARB_STATS_EN
        ,
        .grant_cnt_req              (grant_cnt_req),
        .grant_cnt_dma              (grant_cnt_dma)
`endif
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(input int reqV, input int reqId, input int dmaV,
                                input int isWrite, input int hp, input int dmaId,
                                input int outRdy, input int eReqRdy, input int eDmaRdy,
                                input int eOutV, input int eIsDma, input int eId);
        vec_t v;
        v.reqV    = reqV[0];
        v.reqId   = reqId[3:0];
        v.dmaV    = dmaV[0];
        v.isWrite = isWrite[0];
        v.hp      = hp[0];
        v.dmaId   = dmaId[5:0];
        v.outRdy  = outRdy[0];
        v.eReqRdy = eReqRdy[0];
        v.eDmaRdy = eDmaRdy[0];
        v.eOutV   = eOutV[0];
        v.eIsDma  = eIsDma[0];
        v.eId     = eId[5:0];
        return v;
    endfunction

    // Drive one cycle of channel inputs; addresses encode channel and id.
    task automatic applyStimulus(input vec_t v);
        llc_req_in_valid           = v.reqV;
        llc_req_in_coh_msg         = REQ_GETS;
        llc_req_in_hprot           = 1'b0;
        llc_req_in_addr            = {22'h004, v.reqId};
        llc_req_in_line            = 64'h1111_0000_0000_1111;
        llc_req_in_req_id          = v.reqId;
        llc_req_in_word_offset     = 2'd0;
        llc_req_in_valid_words     = 2'd0;
        llc_dma_req_in_valid       = v.dmaV;
        llc_dma_req_in_coh_msg     = v.isWrite ? REQ_DMA_WRITE : REQ_DMA_READ;
        llc_dma_req_in_hprot       = v.hp;
        llc_dma_req_in_addr        = {20'h008, v.dmaId};
        llc_dma_req_in_line        = 64'h2222_0000_0000_2222;
        llc_dma_req_in_req_id      = v.dmaId;
        llc_dma_req_in_word_offset = 4'd5;
        llc_dma_req_in_valid_words = 4'd9;
        req_out_ready              = v.outRdy;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    vec_t idleV;
    vec_t v;

    initial begin
        total      = 0;
        bad        = 0;
        nReqGrants = 0;
        nDmaGrants = 0;

        // Weighted round-robin from reset (prio=0): REQ, DMA, DMA, REQ, DMA, DMA.
        vecs[0]  = mk(1, 1, 1, 0, 0, 33, 1,  1, 0, 1, 0, 1);
        vecs[1]  = mk(1, 2, 1, 0, 0, 33, 1,  0, 1, 1, 1, 33);
        vecs[2]  = mk(1, 2, 1, 0, 0, 34, 1,  0, 1, 1, 1, 34);
        vecs[3]  = mk(1, 2, 1, 0, 0, 35, 1,  1, 0, 1, 0, 2);
        vecs[4]  = mk(1, 3, 1, 0, 0, 35, 1,  0, 1, 1, 1, 35);
        vecs[5]  = mk(1, 3, 1, 0, 0, 36, 1,  0, 1, 1, 1, 36);
        // Coherence only, four back-to-back GETS.
        vecs[6]  = mk(1, 3, 0, 0, 0, 0,  1,  1, 0, 1, 0, 3);
        vecs[7]  = mk(1, 4, 0, 0, 0, 0,  1,  1, 0, 1, 0, 4);
        vecs[8]  = mk(1, 5, 0, 0, 0, 0,  1,  1, 0, 1, 0, 5);
        vecs[9]  = mk(1, 6, 0, 0, 0, 0,  1,  1, 0, 1, 0, 6);
        // Idle: slot drains.
        vecs[10] = mk(0, 0, 0, 0, 0, 0,  1,  0, 0, 0, 0, 0);
        // 3-line DMA write burst (hprot 1,1,0) with a DMA stall inside the lock.
        vecs[11] = mk(1, 7, 1, 1, 1, 40, 1,  0, 1, 1, 1, 40);
        vecs[12] = mk(1, 7, 1, 1, 1, 41, 1,  0, 1, 1, 1, 41);
        vecs[13] = mk(1, 7, 0, 1, 1, 0,  1,  0, 0, 0, 0, 0);
        vecs[14] = mk(1, 7, 1, 1, 0, 42, 1,  0, 1, 1, 1, 42);
        vecs[15] = mk(1, 7, 1, 0, 0, 43, 1,  1, 0, 1, 0, 7);
        // Back-pressure for 5 cycles, then drain plus grant in one cycle.
        vecs[16] = mk(1, 8, 1, 0, 0, 44, 0,  0, 0, 1, 0, 7);
        vecs[17] = mk(1, 8, 1, 0, 0, 44, 0,  0, 0, 1, 0, 7);
        vecs[18] = mk(1, 8, 1, 0, 0, 44, 0,  0, 0, 1, 0, 7);
        vecs[19] = mk(1, 8, 1, 0, 0, 44, 0,  0, 0, 1, 0, 7);
        vecs[20] = mk(1, 8, 1, 0, 0, 44, 0,  0, 0, 1, 0, 7);
        vecs[21] = mk(1, 8, 1, 0, 0, 44, 1,  0, 1, 1, 1, 44);
        vecs[22] = mk(0, 0, 0, 0, 0, 0,  1,  0, 0, 0, 0, 0);

        idleV = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);

        // Reset with idle inputs.
        rst = 1'b0;
        applyStimulus(idleV);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset out_valid",   64'(req_out_valid),   64'd0);
        checkOutput("reset req_ready",   64'(llc_req_in_ready), 64'd0);
        checkOutput("reset dma_ready",   64'(llc_dma_req_in_ready), 64'd0);
        checkOutput("reset out_addr",    64'(req_out_addr),    64'd0);
        checkOutput("reset out_line",    req_out_line,         64'd0);
        checkOutput("reset out_req_id",  64'(req_out_req_id),  64'd0);
        checkOutput("reset out_msg",     64'(req_out_coh_msg), 64'd0);
        checkOutput("reset out_is_dma",  64'(req_out_is_dma),  64'd0);
        rst = 1'b1;

        // Table-driven cycles: readies checked mid-cycle, outputs after the edge.
        for (int i = 0; i < NUM_VEC; i++) begin
            v = vecs[i];
            @(negedge clk);
            applyStimulus(v);
            #1;
            checkOutput($sformatf("v%0d req_ready", i), 64'(llc_req_in_ready), 64'(v.eReqRdy));
            checkOutput($sformatf("v%0d dma_ready", i), 64'(llc_dma_req_in_ready), 64'(v.eDmaRdy));
            if (v.reqV && v.eReqRdy) nReqGrants++;
            if (v.dmaV && v.eDmaRdy) nDmaGrants++;
            @(posedge clk);
            #1;
            checkOutput($sformatf("v%0d out_valid", i), 64'(req_out_valid), 64'(v.eOutV));
            if (v.eOutV) begin
                checkOutput($sformatf("v%0d out_is_dma", i), 64'(req_out_is_dma), 64'(v.eIsDma));
                checkOutput($sformatf("v%0d out_req_id", i), 64'(req_out_req_id), 64'(v.eId));
                checkOutput($sformatf("v%0d out_addr", i), 64'(req_out_addr),
                            v.eIsDma ? 64'({20'h008, v.eId}) : 64'({22'h004, v.eId[3:0]}));
            end
        end

`ifdef LLC_REQ_ARB_STATS_EN
        checkOutput("stats grant_cnt_req", 64'(grant_cnt_req), 64'(nReqGrants));
        checkOutput("stats grant_cnt_dma", 64'(grant_cnt_dma), 64'(nDmaGrants));
`endif

        // Reset in the middle of a DMA write burst.
        @(negedge clk);
        applyStimulus(mk(0, 0, 1, 1, 1, 50, 1, 0, 0, 0, 0, 0));
        #1;
        checkOutput("burst line1 dma_ready", 64'(llc_dma_req_in_ready), 64'd1);
        @(posedge clk);
        #1;
        checkOutput("burst line1 out_is_dma", 64'(req_out_is_dma), 64'd1);
        @(negedge clk);
        applyStimulus(mk(1, 9, 1, 1, 1, 51, 1, 0, 0, 0, 0, 0));
        llc_req_in_word_offset = 2'd3;
        llc_req_in_valid_words = 2'd2;
        llc_req_in_line        = 64'hDEAD_BEEF_0123_4567;
        rst = 1'b0;
        #1;
        checkOutput("midrst out_valid",  64'(req_out_valid),        64'd0);
        checkOutput("midrst out_is_dma", 64'(req_out_is_dma),       64'd0);
        checkOutput("midrst out_req_id", 64'(req_out_req_id),       64'd0);
        checkOutput("midrst req_ready",  64'(llc_req_in_ready),     64'd0);
        checkOutput("midrst dma_ready",  64'(llc_dma_req_in_ready), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("postrst req_ready", 64'(llc_req_in_ready),     64'd1);
        checkOutput("postrst dma_ready", 64'(llc_dma_req_in_ready), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("postrst out_valid",       64'(req_out_valid),       64'd1);
        checkOutput("postrst out_is_dma",      64'(req_out_is_dma),      64'd0);
        checkOutput("postrst out_req_id",      64'(req_out_req_id),      64'd9);
        checkOutput("postrst out_word_offset", 64'(req_out_word_offset), 64'd3);
        checkOutput("postrst out_valid_words", 64'(req_out_valid_words), 64'd2);
        checkOutput("postrst out_line",        req_out_line,             64'hDEAD_BEEF_0123_4567);

`ifdef LLC_REQ_ARB_STATS_EN
        // Saturation: counter held at all-ones must not wrap on a grant.
        @(negedge clk);
        applyStimulus(idleV);
        force dut.grantCntReq_q = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        release dut.grantCntReq_q;
        applyStimulus(mk(1, 3, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        checkOutput("stats saturate req", 64'(grant_cnt_req), 64'h0000_0000_FFFF_FFFF);
`endif

        @(negedge clk);
        applyStimulus(idleV);
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/llc_req_arbiter.md
# llc_req_arbiter

Two-input arbiter in front of the LLC request pipeline, merging the coherence request channel (`llc_req_in_t` fields from private caches) and the DMA request channel (`llc_dma_req_in_t` fields) into one registered request stream for the LLC core. It applies weighted round-robin between the channels and locks to the DMA channel for the whole of a multi-line DMA write burst. It widens coherence fields to the DMA field widths so the LLC core sees one request format.

## Interface
- `DMA_WEIGHT`, default 1: consecutive DMA grants allowed before the coherence channel gets priority; range 1–15.
- `clk` in 1: clock; all state is on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `llc_req_in_valid` in 1 / `llc_req_in_ready` out 1: coherence channel handshake.
- `llc_req_in_{coh_msg,hprot,addr,line,req_id,word_offset,valid_words}` in: typed `mix_msg_t`, `hprot_t`, `line_addr_t`, `line_t`, `cache_id_t`, `word_offset_t`, `word_offset_t`.
- `llc_dma_req_in_valid` in 1 / `llc_dma_req_in_ready` out 1: DMA channel handshake.
- `llc_dma_req_in_{...}` in: same fields; `req_id` is `llc_coh_dev_id_t`; offsets are `dma_word_offset_t`.
- `req_out_valid` out 1 / `req_out_ready` in 1: merged output handshake.
- `req_out_{coh_msg,hprot,addr,line,req_id,word_offset,valid_words}` out: DMA-width types.
- `req_out_is_dma` out 1: 1 when the request came from the DMA channel.
- `grant_cnt_req`, `grant_cnt_dma` out 32 each: present only with `LLC_REQ_ARB_STATS_EN`.

## Operation
- There is one output register slot. `slot_free = !req_out_valid || req_out_ready`.
- At most one input `ready` is high in any cycle, and only when `slot_free`. A grant happens when the selected channel's `valid && ready`.
- Width conversion for coherence requests: `req_id` and offsets are zero-extended; `is_dma=0`.
- FSM states:
  - **RR**: selects between the channels.
  - **DMA_LOCK**: only the DMA channel is eligible; the coherence channel's `ready` is 0.
- RR selection:
  - If only one channel is valid, it wins.
  - If both are valid, the channel indicated by `prio` wins. `prio` is 1 bit, 0 = coherence.
  - `dma_run` (4-bit) counts consecutive DMA grants.
  - A coherence grant sets `prio=1` and `dma_run=0`.
  - A DMA grant increments `dma_run`. When `dma_run+1 == DMA_WEIGHT`, it sets `prio=0` and `dma_run=0`.
- Burst lock:
  - A granted DMA request with `coh_msg == REQ_DMA_WRITE` and `hprot == 1` (burst continues) moves the FSM RR→DMA_LOCK.
  - In DMA_LOCK, a granted DMA line with `hprot == 0` (burst end) returns the FSM to RR with `prio=0` and `dma_run=0`.
  - Lines inside a burst do not update `dma_run`.
  - `REQ_DMA_READ` never locks; it is a single request.
- In DMA_LOCK with the DMA channel not valid, the arbiter stalls; the coherence channel is not served.
- Reset values:
  - Outputs: `req_out_valid=0`, all `req_out_*` fields 0, both `ready` outputs 0, counters 0.
  - Internal state: FSM=RR, `prio=0`, `dma_run=0`.
- Reset asserted mid-burst abandons the lock. Upstream is reset together with this block.

## Timing
- Latency is 1 cycle: a grant at edge N makes `req_out_valid` high after edge N.
- Full throughput is one request per cycle while `req_out_ready=1`.
- `req_out_*` are stable while `req_out_valid && !req_out_ready`.
- `ready` outputs are combinational from `slot_free`, FSM, `prio` and the two `valid`s. There is no combinational path from input data to outputs.
- Back-pressure: with `req_out_ready=0` and the slot full, both `ready` outputs are 0.
- Simultaneous drain and grant in one cycle loads the new request into the slot; there is no bubble.

## Configuration
- `LLC_REQ_ARB_STATS_EN` defined:
  - Adds `grant_cnt_req` and `grant_cnt_dma`, each incremented on its channel's grant.
  - Both saturate at 0xFFFFFFFF and reset to 0.
- Undefined: the ports and counters are absent, and the rest of the behaviour is identical.

## Structure
- Package `llc_arb_pkg`:
  - FSM enum `llc_arb_state_t` {RR, DMA_LOCK}.
  - Constant `LLC_ARB_RUN_BITS = 4`.
- Reuses `REQ_DMA_WRITE`, `REQ_DMA_READ` and field typedefs from the existing cache constants and types headers.
- Sub-module `llc_arb_out_reg`: a one-entry valid/ready output register holding the merged request plus `is_dma`. It is instantiated once.

## Test plan
- **Coherence only:** 4 back-to-back coherence GETS with `req_out_ready=1` → 4 outputs on consecutive cycles, each 1 cycle after its grant, `is_dma=0`, `req_id` zero-extended.
- **Weighted round-robin:** `DMA_WEIGHT=2`, both channels continuously valid with single-line DMA reads → grant order REQ, DMA, DMA, REQ, DMA, DMA.
- **Burst lock:** DMA write burst of 3 lines (`hprot` 1,1,0) while the coherence channel is valid → `llc_req_in_ready=0` for all 3 DMA grants, and the coherence request is granted in the cycle after the `hprot=0` line.
- **Back-pressure:** `req_out_ready=0` for 5 cycles with both channels valid → both `ready` outputs 0, output fields unchanged. When `ready` rises, the held request drains and the next grant follows the same cycle.
- **Reset mid-burst:** assert `rst=0` after line 1 of a 3-line burst → all outputs 0 and FSM=RR. After release, a coherence request is granted at the first opportunity.
- **Stats (`LLC_REQ_ARB_STATS_EN`):** 7 coherence and 3 DMA grants → `grant_cnt_req=7`, `grant_cnt_dma=3`. With a counter forced to 0xFFFFFFFF, a further grant leaves it at 0xFFFFFFFF.
